// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS bus arbiter.
//   state_t  : arbiter FSM states
//   master_t : identity of the two bus masters (instruction fetch, load/store)
//   ERR_DATA_DEFAULT : read data returned to a master whose transfer timed out
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } master_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/mips_bus_timeout.sv
// Stall counter for the bus arbiter.
// Counts cycles in which `enable` is high, is cleared by `clear`, and raises
// `expired` once the count equals TIMEOUT_CYCLES. A TIMEOUT_CYCLES of 0
// disables expiry altogether.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the count (held while the arbiter is idle)
//   enable     : count this cycle (granted and slave stalling)
//   expired    : count has reached TIMEOUT_CYCLES
module mips_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  // The count holds at LIMIT so expiry cannot wrap back to zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (count == LIMIT);

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master round-robin arbiter sharing one slave between a MIPS core's
// instruction-fetch port and its load/store port.
// Every transfer costs an IDLE (arbitration) cycle plus at least one grant
// cycle. While granted, the master's request is forwarded combinationally
// to the slave and the slave's waitrequest/readdata are returned to it.
// A slave stalling for TIMEOUT_CYCLES grant cycles is abandoned: the master
// is released with ERR_DATA and the sticky bus_error flag is raised.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   instr_* (request in)   : fetch master address/read/write/writedata/byteenable
//   instr_readdata/waitreq : fetch master response
//   data_*                 : load/store master, same shape as instr_*
//   mem_*  (request out)   : shared slave request
//   mem_readdata/waitreq   : shared slave response
//   bus_error              : sticky timeout flag, cleared only by reset
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address,
  input  logic        instr_read,
  input  logic        instr_write,
  input  logic [31:0] instr_writedata,
  input  logic [3:0]  instr_byteenable,
  output logic [31:0] instr_readdata,
  output logic        instr_waitrequest,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  input  logic [3:0]  data_byteenable,
  output logic [31:0] data_readdata,
  output logic        data_waitrequest,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        bus_error
);

  state_t      state;
  state_t      state_nxt;
  master_t     last_grant;
  logic        err_q;
  logic        timeout_now;
  logic        expired;
  logic        i_req;
  logic        d_req;
  logic        dsel;
  logic        g_req;
  logic        granted;
  logic        g_wait;
  logic [31:0] g_rdata;

  assign i_req   = instr_read | instr_write;
  assign d_req   = data_read  | data_write;
  assign dsel    = (state == GRANT_D);
  assign g_req   = dsel ? d_req : i_req;
  assign granted = !reset && (state != IDLE);

  mips_bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == IDLE),
    .enable  (granted && g_req && mem_waitrequest),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= DATA;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt != IDLE) begin
        last_grant <= (state_nxt == GRANT_D) ? DATA : INSTR;
      end
      if (timeout_now) begin
        err_q <= 1'b1;
      end
    end
  end

  // The timeout cycle itself already reports the error, before err_q lands.
  assign bus_error = err_q | timeout_now;

  always_comb begin
    state_nxt         = state;
    mem_address       = '0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_writedata     = '0;
    mem_byteenable    = '0;
    instr_waitrequest = 1'b1;
    data_waitrequest  = 1'b1;
    instr_readdata    = '0;
    data_readdata     = '0;
    g_wait            = 1'b1;
    g_rdata           = '0;
    timeout_now       = 1'b0;

    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (i_req && d_req) begin
            state_nxt = (last_grant == INSTR) ? GRANT_D : GRANT_I;
          end else if (i_req) begin
            state_nxt = GRANT_I;
          end else if (d_req) begin
            state_nxt = GRANT_D;
          end
        end

        GRANT_I, GRANT_D: begin
          mem_address    = dsel ? data_address    : instr_address;
          mem_writedata  = dsel ? data_writedata  : instr_writedata;
          mem_byteenable = dsel ? data_byteenable : instr_byteenable;
          mem_write      = dsel ? data_write      : instr_write;
          // Read and write together is a write.
          mem_read       = (dsel ? data_read : instr_read) & ~mem_write;

          if (!g_req) begin
            // Master withdrew mid-grant: abandon without completing.
            state_nxt = IDLE;
          end else if (expired) begin
            timeout_now = 1'b1;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            g_wait      = 1'b0;
            g_rdata     = ERR_DATA;
            state_nxt   = IDLE;
          end else begin
            g_wait = mem_waitrequest;
            if (!mem_waitrequest) begin
              g_rdata   = mem_readdata;
              state_nxt = IDLE;
            end
          end

          if (dsel) begin
            data_waitrequest  = g_wait;
            data_readdata     = g_rdata;
          end else begin
            instr_waitrequest = g_wait;
            instr_readdata    = g_rdata;
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
module tb_mips_bus_arbiter;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_address, instr_writedata, instr_readdata;
  logic        instr_read, instr_write, instr_waitrequest;
  logic [3:0]  instr_byteenable;
  logic [31:0] data_address, data_writedata, data_readdata;
  logic        data_read, data_write, data_waitrequest;
  logic [3:0]  data_byteenable;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_read, mem_write, mem_waitrequest;
  logic [3:0]  mem_byteenable;
  logic        bus_error;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .instr_address     (instr_address),
    .instr_read        (instr_read),
    .instr_write       (instr_write),
    .instr_writedata   (instr_writedata),
    .instr_byteenable  (instr_byteenable),
    .instr_readdata    (instr_readdata),
    .instr_waitrequest (instr_waitrequest),
    .data_address      (data_address),
    .data_read         (data_read),
    .data_write        (data_write),
    .data_writedata    (data_writedata),
    .data_byteenable   (data_byteenable),
    .data_readdata     (data_readdata),
    .data_waitrequest  (data_waitrequest),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_byteenable    (mem_byteenable),
    .mem_readdata      (mem_readdata),
    .mem_waitrequest   (mem_waitrequest),
    .bus_error         (bus_error)
  );

  typedef struct {
    bit          m;      // 0 = instr, 1 = data
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    bit          to;     // completion is a timeout
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic at_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit m, input logic [31:0] a, input bit w,
                     input logic [31:0] wd, input logic [3:0] be);
    if (m) begin
      data_address = a; data_read = ~w; data_write = w;
      data_writedata = wd; data_byteenable = be;
    end else begin
      instr_address = a; instr_read = ~w; instr_write = w;
      instr_writedata = wd; instr_byteenable = be;
    end
  endtask

  task automatic drop(input bit m);
    if (m) begin data_read = 1'b0; data_write = 1'b0; end
    else   begin instr_read = 1'b0; instr_write = 1'b0; end
  endtask

  task automatic push(input bit m, input logic [31:0] a, input bit w, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] rd, input bit to);
    exp_t e;
    e.m = m; e.addr = a; e.wr = w; e.wdata = wd; e.be = be; e.rdata = rd; e.to = to;
    sb.push_back(e);
  endtask

  // Wait (bounded) for master m to see waitrequest low, then pop and compare.
  task automatic wait_done(input bit m, input int budget, input string tag, output int ncyc);
    exp_t e;
    bit   done;
    logic w, ow;
    logic [31:0] rd;
    done = 0;
    ncyc = 0;
    while (!done && ncyc < budget) begin
      @(negedge clk);
      ncyc++;
      w  = m ? data_waitrequest  : instr_waitrequest;
      ow = m ? instr_waitrequest : data_waitrequest;
      rd = m ? data_readdata     : instr_readdata;
      if (w === 1'b0) begin
        done = 1;
        chk1({tag, "_other_wait"}, ow, 1'b1);
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL %s_sb_empty observed=0 expected>0", tag);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk1({tag, "_master"}, m, e.m);
          chk32({tag, "_rdata"}, rd, e.rdata);
          if (e.to) begin
            chk1({tag, "_to_mem_read"}, mem_read, 1'b0);
            chk1({tag, "_to_mem_write"}, mem_write, 1'b0);
            chk1({tag, "_to_bus_error"}, bus_error, 1'b1);
          end else begin
            chk32({tag, "_addr"}, mem_address, e.addr);
            chk1({tag, "_mem_write"}, mem_write, e.wr);
            chk1({tag, "_mem_read"}, mem_read, ~e.wr);
            if (e.wr) begin
              chk32({tag, "_wdata"}, mem_writedata, e.wdata);
              chk32({tag, "_be"}, {28'd0, mem_byteenable}, {28'd0, e.be});
            end
          end
        end
      end
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL %s_budget observed=no_completion expected=completion_within_%0d", tag, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    instr_address = '0; instr_read = 1'b0; instr_write = 1'b0;
    instr_writedata = '0; instr_byteenable = '0;
    data_address = '0; data_read = 1'b0; data_write = 1'b0;
    data_writedata = '0; data_byteenable = '0;
    mem_readdata = '0; mem_waitrequest = 1'b0;

    // Reset held with requests pending: slave stays quiet.
    instr_read = 1'b1;
    data_write = 1'b1;
    @(negedge clk);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk1("rst_iwait", instr_waitrequest, 1'b1);
    chk1("rst_dwait", data_waitrequest, 1'b1);
    at_edge();
    drop(0); drop(1);
    at_edge();
    reset = 1'b0;
    @(negedge clk);
    chk1("rst_bus_error", bus_error, 1'b0);
    chk1("rst_idle_mem_read", mem_read, 1'b0);

    // Tie after reset: instr, data, instr, data with both held requesting.
    at_edge();
    mem_readdata = 32'hCAFE0000;
    req(0, 32'h0000_0100, 0, '0, 4'hF); push(0, 32'h0000_0100, 0, '0, 4'hF, 32'hCAFE0000, 0);
    req(1, 32'h0000_0200, 0, '0, 4'hF); push(1, 32'h0000_0200, 0, '0, 4'hF, 32'hCAFE0000, 0);
    for (int k = 0; k < 4; k++) begin
      wait_done(k[0], 8, "tie", n);
      chk32("tie_cycles", 32'(n), 32'd2);
      at_edge();
      if (k < 2) begin
        req(k[0], 32'h0000_1000 + 32'(k), 0, '0, 4'hF);
        push(k[0], 32'h0000_1000 + 32'(k), 0, '0, 4'hF, 32'hCAFE0000, 0);
      end else begin
        drop(k[0]);
      end
    end

    // Fetch only, slave ready.
    mem_readdata = 32'h3C1A0001;
    req(0, 32'hBFC00000, 0, '0, 4'hF); push(0, 32'hBFC00000, 0, '0, 4'hF, 32'h3C1A0001, 0);
    wait_done(0, 8, "fetch", n);
    chk32("fetch_cycles", 32'(n), 32'd2);
    chk32("fetch_rdata_pass", instr_readdata, mem_readdata);
    at_edge();
    drop(0);

    // Data write, slave stalls 3 grant cycles.
    mem_waitrequest = 1'b1;
    mem_readdata = 32'h0;
    req(1, 32'h8000_1000, 1, 32'h12345678, 4'b0011);
    push(1, 32'h8000_1000, 1, 32'h12345678, 4'b0011, 32'h0, 0);
    @(negedge clk);
    chk1("wr_idle_mem_write", mem_write, 1'b0);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk1("wr_stall_mem_write", mem_write, 1'b1);
      chk1("wr_stall_mem_read", mem_read, 1'b0);
      chk32("wr_stall_addr", mem_address, 32'h8000_1000);
      chk32("wr_stall_wdata", mem_writedata, 32'h12345678);
      chk32("wr_stall_be", {28'd0, mem_byteenable}, 32'd3);
      chk1("wr_stall_dwait", data_waitrequest, 1'b1);
      chk1("wr_stall_iwait", instr_waitrequest, 1'b1);
    end
    at_edge();
    mem_waitrequest = 1'b0;
    wait_done(1, 4, "wr", n);
    chk32("wr_last_cycle", 32'(n), 32'd1);
    at_edge();
    drop(1);

    // Master withdraws mid-grant: no completion, back to IDLE.
    mem_waitrequest = 1'b1;
    req(0, 32'h0000_0400, 0, '0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk1("viol_granted_mem_read", mem_read, 1'b1);
    at_edge();
    drop(0);
    @(negedge clk);
    chk1("viol_drop_mem_read", mem_read, 1'b0);
    at_edge();
    mem_waitrequest = 1'b0;
    mem_readdata = 32'h0BAD_F00D;
    req(0, 32'h0000_0404, 0, '0, 4'hF); push(0, 32'h0000_0404, 0, '0, 4'hF, 32'h0BAD_F00D, 0);
    wait_done(0, 8, "viol_retry", n);
    chk32("viol_retry_cycles", 32'(n), 32'd2);
    at_edge();
    drop(0);

    // Slave stuck: timeout after TO stall cycles.
    chk1("to_pre_bus_error", bus_error, 1'b0);
    mem_waitrequest = 1'b1;
    mem_readdata = 32'h1111_1111;
    req(1, 32'h0000_0300, 0, '0, 4'hF); push(1, 32'h0000_0300, 0, '0, 4'hF, ERR, 1);
    wait_done(1, 12, "to", n);
    chk32("to_cycles", 32'(n), 32'(TO + 2));
    at_edge();
    drop(1);
    mem_waitrequest = 1'b0;
    @(negedge clk);
    chk1("to_sticky_idle", bus_error, 1'b1);
    at_edge();
    req(0, 32'h0000_0700, 0, '0, 4'hF); push(0, 32'h0000_0700, 0, '0, 4'hF, 32'h1111_1111, 0);
    wait_done(0, 8, "after_to", n);
    chk1("to_sticky_after_xfer", bus_error, 1'b1);
    at_edge();
    drop(0);

    // Reset during a stalled GRANT_D.
    mem_waitrequest = 1'b1;
    req(1, 32'h0000_0500, 0, '0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk1("rs_stall_mem_read", mem_read, 1'b1);
    at_edge();
    reset = 1'b1;
    @(negedge clk);
    chk1("rs_hold_mem_read", mem_read, 1'b0);
    chk1("rs_hold_dwait", data_waitrequest, 1'b1);
    at_edge();
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    mem_readdata = 32'h2222_2222;
    req(0, 32'h0000_0600, 0, '0, 4'hF);
    push(0, 32'h0000_0600, 0, '0, 4'hF, 32'h2222_2222, 0);
    push(1, 32'h0000_0500, 0, '0, 4'hF, 32'h2222_2222, 0);
    @(negedge clk);
    chk1("rs_idle_mem_read", mem_read, 1'b0);
    chk1("rs_bus_error", bus_error, 1'b0);
    chk1("rs_idle_iwait", instr_waitrequest, 1'b1);
    wait_done(0, 4, "rs_tie_i", n);
    chk32("rs_tie_i_cycles", 32'(n), 32'd1);
    at_edge();
    drop(0);
    wait_done(1, 8, "rs_tie_d", n);
    chk32("rs_tie_d_cycles", 32'(n), 32'd2);
    at_edge();
    drop(1);

    chk32("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 Parameters SHALL be:
- TIMEOUT_CYCLES, default 1000, slave-stall cycles before forced completion; 0 disables.
- ERR_DATA, default 32'hDEADBEEF, readdata returned on timeout.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- reset, in, 1, synchronous, active-high.
- instr_address / instr_read / instr_write, in, 32/1/1, fetch master request.
- instr_writedata / instr_byteenable, in, 32/4, fetch master write data and byte lanes.
- instr_readdata / instr_waitrequest, out, 32/1, fetch master response.
- data_address / data_read / data_write, in, 32/1/1, load-store master request.
- data_writedata / data_byteenable, in, 32/4, load-store master write data and byte lanes.
- data_readdata / data_waitrequest, out, 32/1, load-store master response.
- mem_address / mem_read / mem_write, out, 32/1/1, shared slave request.
- mem_writedata / mem_byteenable, out, 32/4, shared slave write data and byte lanes.
- mem_readdata / mem_waitrequest, in, 32/1, shared slave response.
- bus_error, out, 1, sticky timeout flag.

Function
REQ-003 A master SHALL be requesting when its read or write is high; read and write both high SHALL be treated as write.
REQ-004 Masters SHALL hold all request signals stable while their waitrequest is high.
REQ-005 The FSM SHALL have states IDLE, GRANT_I and GRANT_D.
REQ-006 In IDLE, mem_read and mem_write SHALL be 0 and both master waitrequests SHALL be 1.
REQ-007 In IDLE with exactly one requester, the next state SHALL grant that requester.
REQ-008 In IDLE with both requesting, the grant SHALL go to the master not named in the last_grant register (round-robin).
REQ-009 last_grant SHALL be updated to the granted master on every grant.
REQ-010 In GRANT_x, the granted master's address, read, write, writedata and byteenable SHALL drive the mem_* outputs combinationally.
REQ-011 In GRANT_x, the granted master's waitrequest SHALL equal mem_waitrequest, and its readdata SHALL equal mem_readdata.
REQ-012 The non-granted master's waitrequest SHALL be 1 at all times.
REQ-013 A transfer SHALL complete on a GRANT_x cycle with mem_waitrequest=0; the next state SHALL be IDLE.
REQ-014 Minimum cost SHALL be 2 cycles per transfer (arbitration plus grant); no back-to-back grant without IDLE.
REQ-015 If the granted master drops read and write in GRANT_x (protocol violation), mem_read and mem_write SHALL follow it low and the state SHALL return to IDLE next cycle with no completion.
REQ-016 A stall counter SHALL count GRANT_x cycles with mem_waitrequest=1 and clear on entry to GRANT_x.
REQ-017 When the stall count reaches TIMEOUT_CYCLES (non-zero), the arbiter SHALL in that cycle:
- force the granted master's waitrequest=0 and readdata=ERR_DATA;
- drive mem_read=mem_write=0;
- set bus_error;
- go to IDLE.
REQ-018 bus_error SHALL stay set until reset.
REQ-019 The readdata of a master not completing SHALL be 0.

Reset
REQ-020 On reset, the following SHALL take effect at the next clk edge, overriding any in-flight transfer (the transfer is abandoned):
- state=IDLE, last_grant=DATA (so the first tie goes to instr);
- stall counter=0, bus_error=0.
REQ-021 While reset is high, mem_read=mem_write=0 and both master waitrequests SHALL be 1.

Structure
REQ-022 Package mips_bus_pkg SHALL hold the state enum, the master-id enum (INSTR, DATA) and the ERR_DATA default.
REQ-023 The stall counter SHALL be sub-module mips_bus_timeout (clear, enable, expired output, parameterised by TIMEOUT_CYCLES).

Verification
REQ-024 Fetch only: instr_read at 0xBFC00000, mem_waitrequest=0 -> mem_read high in cycle 2, instr_waitrequest=0 that cycle, instr_readdata=mem_readdata.
REQ-025 Tie after reset: both read -> instr granted first, data second, alternating thereafter.
REQ-026 Data write 0x12345678, byteenable 4'b0011, slave stalls 3 cycles -> mem_* stable for 4 grant cycles, data_waitrequest=1 for 3 of them, instr_waitrequest=1 throughout.
REQ-027 TIMEOUT_CYCLES=4, slave waitrequest stuck high -> after 4 stall cycles, master sees waitrequest=0 with readdata=0xDEADBEEF, bus_error=1 until reset.
REQ-028 Reset asserted during a stalled GRANT_D -> next cycle IDLE, mem_read=0, bus_error=0, and the next tie goes to instr.
